// File: rtl/down_timer_arbiter_if.sv
// Bundle between the per-channel sequencers and the shared delay timer.
// The sequencers are the master side; the timer arbiter is the slave side.
interface down_timer_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDW   = 2
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] load_val;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  modport master (
    output req,
    output load_val,
    input  grant,
    input  grant_id,
    input  busy,
    input  count,
    input  done
  );

  modport slave (
    input  req,
    input  load_val,
    output grant,
    output grant_id,
    output busy,
    output count,
    output done
  );

endinterface

// File: rtl/down_timer_arbiter.sv
// Shared down-counting delay timer with a round-robin arbiter in front of it.
// One requester owns the timer at a time; its load value is captured at grant,
// counted down to zero, and answered with a single-cycle done pulse.
module down_timer_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDW   = 2
) (
  input logic                 clk,
  input logic                 rst,
  down_timer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  w_grant_d;
  logic [NREQ-1:0]  r_done;
  logic [NREQ-1:0]  w_done_d;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   w_grant_id_d;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   w_last_d;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;

  logic             w_found;
  logic [IDW-1:0]   w_sel;

  // Round-robin pick: first asserted request scanning upward from last+1.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!w_found && bus.req[(32'(r_last) + k) % NREQ]) begin
        w_found = 1'b1;
        w_sel   = IDW'((32'(r_last) + k) % NREQ);
      end
    end
  end

  // Next-state and registered-output values for the IDLE/RUN/DONE sequence.
  always_comb begin
    w_state_d    = r_state;
    w_grant_d    = r_grant;
    w_grant_id_d = r_grant_id;
    w_count_d    = r_count;
    w_last_d     = r_last;
    w_done_d     = '0;

    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_d        = '0;
          w_grant_d[w_sel] = 1'b1;
          w_grant_id_d     = w_sel;
          w_count_d        = bus.load_val[32'(w_sel) * WIDTH +: WIDTH];
          w_last_d         = w_sel;
          w_state_d        = StRun;
        end
      end

      StRun: begin
        // Abort takes priority over completion in the same cycle.
        if (!bus.req[r_grant_id]) begin
          w_grant_d = '0;
          w_count_d = '0;
          w_state_d = StIdle;
        end else if (r_count == '0) begin
          w_done_d[r_grant_id] = 1'b1;
          w_state_d            = StDone;
        end else begin
          w_count_d = r_count - WIDTH'(1);
        end
      end

      StDone: begin
        // No arbitration here: guarantees an idle cycle between grants.
        w_grant_d = '0;
        w_state_d = StIdle;
      end

      default: begin
        w_grant_d = '0;
        w_count_d = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  // State and output registers; pointer resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_count    <= '0;
      r_done     <= '0;
      r_last     <= IDW'(NREQ - 1);
    end else begin
      r_state    <= w_state_d;
      r_grant    <= w_grant_d;
      r_grant_id <= w_grant_id_d;
      r_count    <= w_count_d;
      r_done     <= w_done_d;
      r_last     <= w_last_d;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_grant_id;
  assign bus.count    = r_count;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != StIdle);

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
  a_done_onehot0  : assert property (@(posedge clk) disable iff (rst) $onehot0(r_done));
  a_done_only_in_done : assert property (
    @(posedge clk) disable iff (rst) (r_done != '0) |-> (r_state == StDone));

endmodule

// File: tb/tb_down_timer_arbiter.sv
// Scoreboard bench for down_timer_arbiter: each scenario pushes the expected
// per-cycle output snapshots, then pops and compares one per clock.
module tb_down_timer_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic [3:0] count;
    logic [3:0] done;
  } snap_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];
  snap_t obs;

  down_timer_arbiter_if #(.NREQ(4), .WIDTH(4), .IDW(2)) bus ();

  down_timer_arbiter #(
    .NREQ (4),
    .WIDTH(4),
    .IDW  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Sample outputs at the falling edge; requesters drop req once they see done.
  task automatic next_cycle();
    @(negedge clk);
    obs = {bus.grant, bus.grant_id, bus.busy, bus.count, bus.done};
    bus.req = bus.req & ~bus.done;
  endtask

  // Expected trace of one full grant: L+1 RUN cycles, one DONE, one IDLE.
  task automatic push_grant(input int id, input int l);
    snap_t      e;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    for (int k = l; k >= 0; k--) begin
      e = {oh, 2'(id), 1'b1, 4'(k), 4'b0000};
      exp_q.push_back(e);
    end
    e = {oh, 2'(id), 1'b1, 4'd0, oh};
    exp_q.push_back(e);
    e = {4'b0000, 2'(id), 1'b0, 4'd0, 4'b0000};
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.req      = '0;
    bus.load_val = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    snap_t e;
    int    guard;
    @(negedge clk);
    bus.req      = '0;
    bus.load_val = '0;
    rst          = 1'b1;
    #1;
    obs = {bus.grant, bus.grant_id, bus.busy, bus.count, bus.done};
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL reset_asserted: got %b required %b", obs, 14'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) exp_q.push_back(14'd0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_idle step %0d: got %b required %b", guard, obs, e);
      end
      guard++;
    end
  endtask

  task automatic test_single();
    snap_t e;
    int    guard;
    apply_reset();
    bus.load_val[3:0] = 4'd3;
    bus.req           = 4'b0001;
    push_grant(0, 3);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single step %0d: got g=%b id=%0d busy=%b cnt=%0d done=%b required g=%b id=%0d busy=%b cnt=%0d done=%b",
                 guard, obs.grant, obs.id, obs.busy, obs.count, obs.done,
                 e.grant, e.id, e.busy, e.count, e.done);
      end
      guard++;
    end
  endtask

  task automatic test_round_robin();
    snap_t e;
    int    guard;
    apply_reset();
    bus.load_val = 16'h1111;
    bus.req      = 4'b1111;
    for (int i = 0; i < 4; i++) push_grant(i, 1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL round_robin step %0d: got g=%b id=%0d busy=%b cnt=%0d done=%b required g=%b id=%0d busy=%b cnt=%0d done=%b",
                 guard, obs.grant, obs.id, obs.busy, obs.count, obs.done,
                 e.grant, e.id, e.busy, e.count, e.done);
      end
      guard++;
    end
  endtask

  task automatic test_rotate();
    snap_t e;
    int    guard;
    apply_reset();
    bus.load_val = 16'h1111;
    bus.req      = 4'b0100;
    push_grant(2, 1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      if (exp_q.size() == 1) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL rotate_first_idle: got %b required %b", obs, e);
        end
        // Pointer now at 2: 0 must beat a re-request from 2.
        bus.req = 4'b0101;
        push_grant(0, 1);
        push_grant(2, 1);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL rotate step %0d: got g=%b id=%0d busy=%b cnt=%0d done=%b required g=%b id=%0d busy=%b cnt=%0d done=%b",
                   guard, obs.grant, obs.id, obs.busy, obs.count, obs.done,
                   e.grant, e.id, e.busy, e.count, e.done);
        end
      end
      guard++;
    end
  endtask

  task automatic test_load_bounds();
    snap_t e;
    int    guard;
    apply_reset();
    bus.load_val = 16'h0000;
    bus.req      = 4'b0001;
    push_grant(0, 0);
    push_grant(1, 15);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_bounds step %0d: got g=%b id=%0d busy=%b cnt=%0d done=%b required g=%b id=%0d busy=%b cnt=%0d done=%b",
                 guard, obs.grant, obs.id, obs.busy, obs.count, obs.done,
                 e.grant, e.id, e.busy, e.count, e.done);
      end
      // After the L=0 transaction ends, launch the L=15 one.
      if (guard == 2) begin
        bus.load_val = 16'h00F0;
        bus.req      = 4'b0010;
      end
      // Changing load_val mid-run must not disturb the count.
      if (guard == 5) bus.load_val = 16'h2222;
      guard++;
    end
  endtask

  task automatic test_abort();
    snap_t e;
    int    guard;
    apply_reset();
    bus.load_val[3:0] = 4'd5;
    bus.req           = 4'b0001;
    for (int k = 5; k >= 2; k--) exp_q.push_back({4'b0001, 2'd0, 1'b1, 4'(k), 4'b0000});
    for (int k = 0; k < 2; k++) exp_q.push_back({4'b0000, 2'd0, 1'b0, 4'd0, 4'b0000});
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_mid step %0d: got g=%b busy=%b cnt=%0d done=%b required g=%b busy=%b cnt=%0d done=%b",
                 guard, obs.grant, obs.busy, obs.count, obs.done,
                 e.grant, e.busy, e.count, e.done);
      end
      if (guard == 3) bus.req = 4'b0000;
      guard++;
    end

    bus.load_val[7:4] = 4'd1;
    bus.req           = 4'b0010;
    exp_q.push_back({4'b0010, 2'd1, 1'b1, 4'd1, 4'b0000});
    exp_q.push_back({4'b0010, 2'd1, 1'b1, 4'd0, 4'b0000});
    for (int k = 0; k < 2; k++) exp_q.push_back({4'b0000, 2'd1, 1'b0, 4'd0, 4'b0000});
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_at_zero step %0d: got g=%b busy=%b cnt=%0d done=%b required g=%b busy=%b cnt=%0d done=%b",
                 guard, obs.grant, obs.busy, obs.count, obs.done,
                 e.grant, e.busy, e.count, e.done);
      end
      if (guard == 1) bus.req = 4'b0000;
      guard++;
    end
  endtask

  task automatic test_reset_midrun();
    snap_t e;
    int    guard;
    apply_reset();
    bus.load_val[3:0] = 4'd7;
    bus.req           = 4'b0001;
    for (int k = 7; k >= 5; k--) exp_q.push_back({4'b0001, 2'd0, 1'b1, 4'(k), 4'b0000});
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL midrun_count step %0d: got cnt=%0d g=%b required cnt=%0d g=%b",
                 guard, obs.count, obs.grant, e.count, e.grant);
      end
      guard++;
    end
    // Asynchronous reset between clock edges.
    #2;
    rst     = 1'b1;
    bus.req = 4'b0000;
    #1;
    obs = {bus.grant, bus.grant_id, bus.busy, bus.count, bus.done};
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL async_reset: got g=%b id=%0d busy=%b cnt=%0d done=%b required all zero",
               obs.grant, obs.id, obs.busy, obs.count, obs.done);
    end
    @(negedge clk);
    rst               = 1'b0;
    bus.load_val[15:12] = 4'd2;
    bus.req           = 4'b1000;
    push_grant(3, 2);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL after_reset step %0d: got g=%b id=%0d busy=%b cnt=%0d done=%b required g=%b id=%0d busy=%b cnt=%0d done=%b",
                 guard, obs.grant, obs.id, obs.busy, obs.count, obs.done,
                 e.grant, e.id, e.busy, e.count, e.done);
      end
      guard++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.load_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_rotate();
    test_load_bounds();
    test_abort();
    test_reset_midrun();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
